// File: rtl/apu_pkg.sv
// Shared APU definitions: default channel width, channel indices and mute mask type.
package apu_pkg;

    localparam int unsigned CH_WIDTH_DFLT = 9;
    localparam int unsigned NUM_CH        = 4;

    typedef enum logic [1:0] {
        CH_PULSE1   = 2'd0,
        CH_PULSE2   = 2'd1,
        CH_TRIANGLE = 2'd2,
        CH_NOISE    = 2'd3
    } ch_idx_e;

    typedef logic [NUM_CH-1:0] mute_mask_t;

endpackage

// File: rtl/apu_mixer_if.sv
// Mixer bus: channel capture inputs plus scaled sample and PDM outputs.
interface apu_mixer_if
    import apu_pkg::*;
#(
    parameter int unsigned CH_WIDTH  = CH_WIDTH_DFLT,
    parameter int unsigned OUT_WIDTH = 16
);

    logic                 i_sample_stb;
    logic [CH_WIDTH-1:0]  i_ch1;
    logic [CH_WIDTH-1:0]  i_ch2;
    logic [CH_WIDTH-1:0]  i_ch3;
    logic [CH_WIDTH-1:0]  i_ch4;
    mute_mask_t           i_mute;
    logic [3:0]           i_master_vol;
    logic [OUT_WIDTH-1:0] o_sample;
    logic                 o_sample_valid;
    logic                 o_pdm;

    modport master (
        output i_sample_stb, i_ch1, i_ch2, i_ch3, i_ch4, i_mute, i_master_vol,
        input  o_sample, o_sample_valid, o_pdm
    );

    modport slave (
        input  i_sample_stb, i_ch1, i_ch2, i_ch3, i_ch4, i_mute, i_master_vol,
        output o_sample, o_sample_valid, o_pdm
    );

endinterface

// File: rtl/apu_sigma_delta.sv
// First-order sigma-delta modulator: carry out of a running sum forms the bitstream.
module apu_sigma_delta #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_level,
    output logic             o_pdm
);

    logic [WIDTH:0] acc_d, acc_q;
    logic           pdm_d, pdm_q;

    // Carry is dropped before each add and emitted one cycle later.
    always_comb begin
        acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, i_level};
        pdm_d = acc_q[WIDTH];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pdm_q <= pdm_d;
        end
    end

    assign o_pdm = pdm_q;

endmodule

// File: rtl/apu_mixer.sv
// Four-channel APU mixer: capture/mute, adder tree, volume scale (4-stage pipeline).
// Define APU_MIXER_SIGMA_DELTA_EN to drive o_pdm from a sigma-delta modulator.
module apu_mixer
    import apu_pkg::*;
#(
    parameter int unsigned CH_WIDTH  = CH_WIDTH_DFLT,
    parameter int unsigned OUT_WIDTH = 16
) (
    input logic        i_clk,
    input logic        i_rst_n,
    apu_mixer_if.slave bus
);

    localparam int unsigned PAIR_W = CH_WIDTH + 1;
    localparam int unsigned SUM_W  = CH_WIDTH + 2;
    localparam int unsigned PROD_W = CH_WIDTH + 6;
    localparam int unsigned SHIFT  = OUT_WIDTH - PROD_W;

    logic [CH_WIDTH-1:0]  ch_in [NUM_CH];
    logic [CH_WIDTH-1:0]  ch_d  [NUM_CH];
    logic [CH_WIDTH-1:0]  ch_q  [NUM_CH];
    logic [3:0]           vol0_d, vol0_q, vol1_d, vol1_q, vol2_d, vol2_q;
    logic                 v0_d, v0_q, v1_d, v1_q, v2_d, v2_q;
    logic [PAIR_W-1:0]    a_d, a_q, b_d, b_q;
    logic [SUM_W-1:0]     sum_d, sum_q;
    logic [PROD_W-1:0]    prod;
    logic [OUT_WIDTH-1:0] sample_d, sample_q;
    logic                 valid_d, valid_q;
    logic                 pdm;

    assign ch_in[CH_PULSE1]   = bus.i_ch1;
    assign ch_in[CH_PULSE2]   = bus.i_ch2;
    assign ch_in[CH_TRIANGLE] = bus.i_ch3;
    assign ch_in[CH_NOISE]    = bus.i_ch4;

    always_comb begin
        v0_d   = bus.i_sample_stb;
        vol0_d = vol0_q;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            ch_d[n] = ch_q[n];
        end
        if (bus.i_sample_stb) begin
            vol0_d = bus.i_master_vol;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                ch_d[n] = bus.i_mute[n] ? '0 : ch_in[n];
            end
        end

        a_d    = PAIR_W'(ch_q[CH_PULSE1]) + PAIR_W'(ch_q[CH_PULSE2]);
        b_d    = PAIR_W'(ch_q[CH_TRIANGLE]) + PAIR_W'(ch_q[CH_NOISE]);
        vol1_d = vol0_q;
        v1_d   = v0_q;

        sum_d  = SUM_W'(a_q) + SUM_W'(b_q);
        vol2_d = vol1_q;
        v2_d   = v1_q;

        // Max 2044*15 fits PROD_W bits, so the scaled result needs no clipping.
        prod     = PROD_W'(sum_q) * PROD_W'(vol2_q);
        sample_d = v2_q ? (OUT_WIDTH'(prod) << SHIFT) : sample_q;
        valid_d  = v2_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                ch_q[n] <= '0;
            end
            vol0_q   <= '0;
            vol1_q   <= '0;
            vol2_q   <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                ch_q[n] <= ch_d[n];
            end
            vol0_q   <= vol0_d;
            vol1_q   <= vol1_d;
            vol2_q   <= vol2_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

`ifdef APU_MIXER_SIGMA_DELTA_EN
    apu_sigma_delta #(
        .WIDTH(OUT_WIDTH)
    ) u_sigma_delta (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_level(sample_q),
        .o_pdm  (pdm)
    );
`else
    assign pdm = 1'b0;
`endif

    assign bus.o_sample       = sample_q;
    assign bus.o_sample_valid = valid_q;
    assign bus.o_pdm          = pdm;

endmodule

// File: tb/tb_apu_mixer.sv
// Directed bench for apu_mixer: reset, mixing/muting/volume, back-to-back strobes, reset flush, PDM.
module tb_apu_mixer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   ones;

    apu_mixer_if #(.CH_WIDTH(9), .OUT_WIDTH(16)) bus ();

    apu_mixer #(
        .CH_WIDTH (9),
        .OUT_WIDTH(16)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic stb, input logic [8:0] c1, input logic [8:0] c2,
                         input logic [8:0] c3, input logic [8:0] c4,
                         input logic [3:0] mute, input logic [3:0] vol);
        bus.i_sample_stb = stb;
        bus.i_ch1        = c1;
        bus.i_ch2        = c2;
        bus.i_ch3        = c3;
        bus.i_ch4        = c4;
        bus.i_mute       = mute;
        bus.i_master_vol = vol;
    endtask

    // One strobe, garbage inputs afterwards; valid must appear exactly on the 4th edge.
    task automatic one_shot(input string tag, input logic [8:0] c1, input logic [8:0] c2,
                            input logic [8:0] c3, input logic [8:0] c4,
                            input logic [3:0] mute, input logic [3:0] vol,
                            input logic [15:0] exp);
        drive(1'b1, c1, c2, c3, c4, mute, vol);
        tick();
        drive(1'b0, 9'h0AA, 9'h155, 9'h033, 9'h1C7, 4'b0101, 4'd3);
        check({tag, "_v_n1"}, {31'b0, bus.o_sample_valid}, 32'd0);
        tick();
        check({tag, "_v_n2"}, {31'b0, bus.o_sample_valid}, 32'd0);
        tick();
        check({tag, "_v_n3"}, {31'b0, bus.o_sample_valid}, 32'd0);
        tick();
        check({tag, "_v_n4"}, {31'b0, bus.o_sample_valid}, 32'd1);
        check({tag, "_sample"}, {16'b0, bus.o_sample}, {16'b0, exp});
        tick();
        check({tag, "_v_n5"}, {31'b0, bus.o_sample_valid}, 32'd0);
        check({tag, "_hold"}, {16'b0, bus.o_sample}, {16'b0, exp});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, '0);

        // Reset held with random activity on the inputs
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom),
                  4'($urandom), 4'($urandom));
            tick();
            check("rst_sample", {16'b0, bus.o_sample}, 32'd0);
            check("rst_valid", {31'b0, bus.o_sample_valid}, 32'd0);
            check("rst_pdm", {31'b0, bus.o_pdm}, 32'd0);
        end
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", {31'b0, bus.o_sample_valid}, 32'd0);

        // Full scale: 2044*15<<1
        one_shot("full", 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 4'b0000, 4'd15, 16'hEF88);
        // Noise muted: 600*8<<1
        one_shot("mute_noise", 9'd100, 9'd200, 9'd300, 9'd400, 4'b1000, 4'd8, 16'd9600);
        // Pulse 1 muted: 900*8<<1
        one_shot("mute_p1", 9'd100, 9'd200, 9'd300, 9'd400, 4'b0001, 4'd8, 16'd14400);
        one_shot("mute_all", 9'd100, 9'd200, 9'd300, 9'd400, 4'b1111, 4'd8, 16'd0);
        // Volume zero: output 0, valid still pulses
        one_shot("vol0", 9'h1FF, 9'd7, 9'd9, 9'd11, 4'b0000, 4'd0, 16'd0);

        // Back-to-back strobes with sums 10, 20, 30 at vol 1
        drive(1'b1, 9'd10, 9'd0, 9'd0, 9'd0, 4'b0000, 4'd1);
        tick();
        drive(1'b1, 9'd5, 9'd15, 9'd0, 9'd0, 4'b0000, 4'd1);
        tick();
        drive(1'b1, 9'd0, 9'd0, 9'd30, 9'd0, 4'b0000, 4'd1);
        tick();
        drive(1'b0, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 4'b0110, 4'd15);
        check("b2b_v_pre", {31'b0, bus.o_sample_valid}, 32'd0);
        tick();
        check("b2b_v0", {31'b0, bus.o_sample_valid}, 32'd1);
        check("b2b_s0", {16'b0, bus.o_sample}, 32'd20);
        tick();
        check("b2b_v1", {31'b0, bus.o_sample_valid}, 32'd1);
        check("b2b_s1", {16'b0, bus.o_sample}, 32'd40);
        tick();
        check("b2b_v2", {31'b0, bus.o_sample_valid}, 32'd1);
        check("b2b_s2", {16'b0, bus.o_sample}, 32'd60);
        tick();
        check("b2b_v3", {31'b0, bus.o_sample_valid}, 32'd0);
        check("b2b_hold", {16'b0, bus.o_sample}, 32'd60);

        // Reset pulsed two cycles after a strobe flushes the pipeline
        drive(1'b1, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 4'b0000, 4'd15);
        tick();
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        tick();
        rst_n = 1'b0;
        #1;
        check("flush_async_s", {16'b0, bus.o_sample}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("flush_v", {31'b0, bus.o_sample_valid}, 32'd0);
            check("flush_s", {16'b0, bus.o_sample}, 32'd0);
        end

        // Hold o_sample at 16'h4000 (1024*8<<1) and count PDM ones
        one_shot("pdm_lvl", 9'd256, 9'd256, 9'd256, 9'd256, 4'b0000, 4'd8, 16'h4000);
        for (int i = 0; i < 4; i++) tick();
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (bus.o_pdm === 1'b1) ones++;
        end
`ifdef APU_MIXER_SIGMA_DELTA_EN
        check("pdm_ones", 32'(ones), 32'd256);
`else
        check("pdm_ones", 32'(ones), 32'd0);
`endif
        check("pdm_sample_held", {16'b0, bus.o_sample}, 32'h4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
